// File: rtl/cu_module_pkg.sv
// Shared definitions for the accumulator control unit slice.
// Holds the bus widths, the ALU opcode map, the flag bit positions,
// the instruction field layout, the FSM state encoding and the
// instruction classes produced by the decoder.
package cu_module_pkg;

    localparam int opsize    = 3;
    localparam int aluwidth  = 16;
    localparam int numflags  = 4;
    localparam int adlines   = 5;
    localparam int datalines = 16;

    // ALU opcode map (the ALU itself lives outside this block)
    localparam logic [opsize-1:0] ALU_AND  = 3'b000;
    localparam logic [opsize-1:0] ALU_OR   = 3'b001;
    localparam logic [opsize-1:0] ALU_XOR  = 3'b010;
    localparam logic [opsize-1:0] ALU_NOT  = 3'b011;
    localparam logic [opsize-1:0] ALU_SUB  = 3'b100;
    localparam logic [opsize-1:0] ALU_SHL  = 3'b101;
    localparam logic [opsize-1:0] ALU_ADD  = 3'b110;
    localparam logic [opsize-1:0] ALU_PASS = 3'b111;

    // Non-memory (M=0) opcodes
    localparam logic [opsize-1:0] OP_JZ    = 3'b001;
    localparam logic [opsize-1:0] OP_JMP   = 3'b010;
    localparam logic [opsize-1:0] OP_LOAD  = 3'b110;
    localparam logic [opsize-1:0] OP_STORE = 3'b111;

    // Flag bit positions within {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Instruction word layout
    localparam int IR_M_BIT   = 8;
    localparam int IR_ADDR_HI = 7;
    localparam int IR_ADDR_LO = 3;
    localparam int IR_OP_HI   = 2;
    localparam int IR_OP_LO   = 0;

    localparam logic [adlines-1:0] PC_RESET = 5'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPREAD,
        S_EXEC,
        S_ST_SETUP,
        S_ST_WR,
        S_ST_HOLD,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        I_NOP,
        I_HALT,
        I_LOAD,
        I_STORE,
        I_ALU,
        I_JMP,
        I_JZ
    } iclass_t;

endpackage

// File: rtl/cu_module_if.sv
// Bus bundle between the control unit and its RAM/ALU neighbours.
//   master : control unit side (drives address, strobes, write data, ALU operands)
//   slave  : environment side (drives RAM read data, ALU result and flags)
interface cu_module_if;
    import cu_module_pkg::*;

    logic [opsize-1:0]    aluopcode;
    logic [aluwidth-1:0]  aluin1;
    logic [aluwidth-1:0]  aluin2;
    logic [aluwidth-1:0]  aluout;
    logic [numflags-1:0]  flags;
    logic [adlines-1:0]   addressbus;
    logic [datalines-1:0] fromram;
    logic [datalines-1:0] toram;
    logic                 read;
    logic                 write;

    modport master (
        output aluopcode, aluin1, aluin2, addressbus, toram, read, write,
        input  aluout, flags, fromram
    );

    modport slave (
        input  aluopcode, aluin1, aluin2, addressbus, toram, read, write,
        output aluout, flags, fromram
    );

endinterface

// File: rtl/cu_module_decode.sv
// cu_decode: combinational classification of the low nine instruction bits.
//   ir_low : instruction bits [8:0] (M, addr, op)
//   iclass : HALT / LOAD / STORE / ALU / JMP / JZ / NOP
module cu_decode
    import cu_module_pkg::*;
(
    input  logic [IR_M_BIT:0] ir_low,
    output iclass_t           iclass
);

    logic [opsize-1:0] op;

    assign op = ir_low[IR_OP_HI:IR_OP_LO];

    always_comb begin
        iclass = I_NOP;
        if (ir_low == '0) begin
            iclass = I_HALT;
        end else if (ir_low[IR_M_BIT]) begin
            iclass = I_ALU;
        end else begin
            case (op)
                OP_LOAD:  iclass = I_LOAD;
                OP_STORE: iclass = I_STORE;
                OP_JMP:   iclass = I_JMP;
                OP_JZ:    iclass = I_JZ;
                default:  iclass = I_NOP;
            endcase
        end
    end

endmodule

// File: rtl/cu_module.sv
// cu_module: multi-cycle accumulator control unit.
// Fetches from a level-sensitive RAM, drives a combinational ALU and
// sequences LOAD / STORE / ALU / JMP / JZ / NOP / HALT.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   enable  : run enable, sampled at instruction boundaries
//   halted  : high while in HALT
//   bus     : RAM address/data/strobes and ALU operands/result/flags
module cu_module
    import cu_module_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        halted,
    cu_module_if.master bus
);

    state_t               state;
    state_t               state_nx;
    iclass_t              iclass;
    logic [adlines-1:0]   pc;
    logic [datalines-1:0] ir;
    logic [aluwidth-1:0]  acc;
    logic [aluwidth-1:0]  mdr;
    logic [numflags-1:0]  flg;
    logic                 write_q;
    logic [adlines-1:0]   ir_addr;
    logic                 unused_bits;

    assign ir_addr = ir[IR_ADDR_HI:IR_ADDR_LO];

    // Upper instruction bits carry no meaning; only Z is consulted by JZ.
    assign unused_bits = ^{ir[datalines-1:IR_M_BIT+1], flg[numflags-1:1]};

    cu_decode u_decode (
        .ir_low (ir[IR_M_BIT:0]),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (enable) state_nx = S_FETCH;
            S_FETCH:    state_nx = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    I_HALT:        state_nx = S_HALT;
                    I_LOAD, I_ALU: state_nx = S_OPREAD;
                    I_STORE:       state_nx = S_ST_SETUP;
                    default:       state_nx = enable ? S_FETCH : S_IDLE;
                endcase
            end
            S_OPREAD:   state_nx = S_EXEC;
            S_EXEC:     state_nx = enable ? S_FETCH : S_IDLE;
            S_ST_SETUP: state_nx = S_ST_WR;
            S_ST_WR:    state_nx = S_ST_HOLD;
            S_ST_HOLD:  state_nx = enable ? S_FETCH : S_IDLE;
            S_HALT:     state_nx = S_HALT;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= PC_RESET;
            ir  <= '0;
            acc <= '0;
            mdr <= '0;
            flg <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= bus.fromram;
                    pc <= pc + 1'b1;
                end
                S_DECODE: begin
                    if (iclass == I_JMP || (iclass == I_JZ && flg[FLAG_Z])) begin
                        pc <= ir_addr;
                    end
                end
                S_OPREAD: mdr <= bus.fromram;
                S_EXEC: begin
                    // Only LOAD and ALU instructions reach EXEC.
                    if (iclass == I_ALU) begin
                        acc <= bus.aluout;
                        flg <= bus.flags;
                    end else begin
                        acc <= mdr;
                    end
                end
                default: ;
            endcase
        end
    end

    // The RAM writes while write is high, so the strobe comes straight
    // from a flop rather than a state decode that could glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
        end else begin
            write_q <= (state_nx == S_ST_WR);
        end
    end

    always_comb begin
        bus.read       = 1'b0;
        bus.addressbus = '0;
        bus.toram      = '0;
        bus.aluopcode  = '0;
        case (state)
            S_FETCH: begin
                bus.read       = 1'b1;
                bus.addressbus = pc;
            end
            S_OPREAD: begin
                bus.read       = 1'b1;
                bus.addressbus = ir_addr;
            end
            S_EXEC: bus.aluopcode = ir[IR_OP_HI:IR_OP_LO];
            S_ST_SETUP, S_ST_WR, S_ST_HOLD: begin
                bus.addressbus = ir_addr;
                bus.toram      = acc;
            end
            default: ;
        endcase
    end

    assign bus.write  = write_q;
    assign bus.aluin1 = acc;
    assign bus.aluin2 = mdr;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_cu_module.sv
`timescale 1ns/1ps
module tb_cu_module;
    import cu_module_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic halted;

    cu_module_if bus();

    cu_module dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .halted (halted),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- environment: ALU and RAM ----------------
    function automatic logic [19:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        w = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~a;
            3'd4: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd5: begin
                r = {a[14:0], 1'b0};
                c = a[15];
                v = a[15] ^ a[14];
            end
            3'd6: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            default: r = b;
        endcase
        return {v, c, r[15], (r == 16'h0), r};
    endfunction

    assign {bus.flags, bus.aluout} = alu_f(bus.aluopcode, bus.aluin1, bus.aluin2);

    logic [15:0] prog [32];
    logic [15:0] ram  [32];

    assign bus.fromram = bus.read ? ram[bus.addressbus] : 16'hDEAD;

    always @(posedge clk) begin
        if (!rst_n) ram <= prog;
        else if (bus.write) ram[bus.addressbus] <= bus.toram;
    end

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic [1:0]  ph;   // 0 other, 1 fetch, 2 halted
        logic        rd;
        logic        wr;
        logic [4:0]  ad;
        logic [15:0] tr;
        logic [2:0]  op;
        logic        hlt;
        logic [15:0] a1;
        logic [15:0] a2;
    } rec_t;

    function automatic rec_t mk(input logic [1:0] ph, input logic rd, input logic wr,
                                input logic [4:0] ad, input logic [15:0] tr, input logic [2:0] op,
                                input logic hlt, input logic [15:0] a1, input logic [15:0] a2);
        rec_t r;
        r.ph = ph; r.rd = rd; r.wr = wr; r.ad = ad; r.tr = tr;
        r.op = op; r.hlt = hlt; r.a1 = a1; r.a2 = a2;
        return r;
    endfunction

    rec_t        q[$];
    rec_t        cur;
    logic [15:0] m_mem [32];
    logic [4:0]  m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_mdr;
    logic [3:0]  m_flg;
    bit          m_halt;

    // Expand the next instruction into its expected per-cycle bus activity
    // and apply its architectural effect.
    task automatic plan_next();
        logic [15:0] w;
        logic [4:0]  a;
        logic [2:0]  op;
        logic [19:0] ar;
        if (m_halt) begin
            q.push_back(mk(2'd2, 0, 0, 5'd0, 16'd0, 3'd0, 1, m_acc, m_mdr));
            return;
        end
        if (!enable) begin
            q.push_back(mk(2'd0, 0, 0, 5'd0, 16'd0, 3'd0, 0, m_acc, m_mdr));
            return;
        end
        w  = m_mem[m_pc];
        a  = w[7:3];
        op = w[2:0];
        q.push_back(mk(2'd1, 1, 0, m_pc, 16'd0, 3'd0, 0, m_acc, m_mdr));
        q.push_back(mk(2'd0, 0, 0, 5'd0, 16'd0, 3'd0, 0, m_acc, m_mdr));
        m_pc = m_pc + 5'd1;
        if (w[8:0] == 9'd0) begin
            m_halt = 1;
        end else if (w[8] || op == 3'b110) begin
            q.push_back(mk(2'd0, 1, 0, a, 16'd0, 3'd0, 0, m_acc, m_mdr));
            m_mdr = m_mem[a];
            q.push_back(mk(2'd0, 0, 0, 5'd0, 16'd0, op, 0, m_acc, m_mdr));
            if (w[8]) begin
                ar    = alu_f(op, m_acc, m_mdr);
                m_acc = ar[15:0];
                m_flg = ar[19:16];
            end else begin
                m_acc = m_mdr;
            end
        end else if (op == 3'b111) begin
            q.push_back(mk(2'd0, 0, 0, a, m_acc, 3'd0, 0, m_acc, m_mdr));
            q.push_back(mk(2'd0, 0, 1, a, m_acc, 3'd0, 0, m_acc, m_mdr));
            q.push_back(mk(2'd0, 0, 0, a, m_acc, 3'd0, 0, m_acc, m_mdr));
            m_mem[a] = m_acc;
        end else if (op == 3'b010) begin
            m_pc = a;
        end else if (op == 3'b001 && m_flg[0]) begin
            m_pc = a;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_pc   = 5'd1;
            m_acc  = 16'd0;
            m_mdr  = 16'd0;
            m_flg  = 4'd0;
            m_halt = 0;
            m_mem  = prog;
            cur    = mk(2'd0, 0, 0, 5'd0, 16'd0, 3'd0, 0, 16'd0, 16'd0);
        end else begin
            if (q.size() == 0) plan_next();
            cur = q.pop_front();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0] fetch_log[$];
    int         wr_cnt;
    logic [4:0] wr_addr;
    logic [15:0] wr_data;

    always @(negedge clk) begin
        if (rst_n) begin
            check("read",       bus.read,       cur.rd);
            check("write",      bus.write,      cur.wr);
            check("addressbus", bus.addressbus, cur.ad);
            check("toram",      bus.toram,      cur.tr);
            check("aluopcode",  bus.aluopcode,  cur.op);
            check("halted",     halted,         cur.hlt);
            check("aluin1",     bus.aluin1,     cur.a1);
            check("aluin2",     bus.aluin2,     cur.a2);
            check("rw_excl",    bus.read & bus.write, 1'b0);
            if (cur.ph == 2'd1) fetch_log.push_back(bus.addressbus);
            if (bus.write) begin
                wr_cnt++;
                wr_addr = bus.addressbus;
                wr_data = bus.toram;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    endtask

    task automatic start(input logic en);
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        fetch_log.delete();
        wr_cnt = 0;
        enable = en;
        rst_n  = 1'b1;
    endtask

    task automatic run_to_halt(input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!halted) begin
            checks++;
            failures++;
            $display("FAIL halt_timeout actual=%0d required=halted", n);
        end
    endtask

    function automatic logic [4:0] fl(input int i);
        if (i < fetch_log.size()) return fetch_log[i];
        return 5'h1f;
    endfunction

    task automatic add_prog();
        clear_prog();
        prog[16] = 16'd5;
        prog[17] = 16'd2;
        prog[1]  = 16'h0086;   // LOAD 16
        prog[2]  = 16'h018E;   // ADD 17
        prog[3]  = 16'h0000;   // HALT
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        add_prog();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read",  bus.read, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_addr",  bus.addressbus, 5'd0);
        check("rst_acc",   bus.aluin1, 16'd0);
        check("rst_halt",  halted, 1'b0);

        // Add program: 5 + 2
        start(1'b1);
        run_to_halt(40);
        check("add_acc",       bus.aluin1, 16'd7);
        check("add_model_acc", m_acc, 16'd7);
        check("add_halted",    halted, 1'b1);
        check("add_nfetch",    fetch_log.size(), 3);
        check("add_lastfetch", fl(2), 5'd3);

        // Store: LOAD 16, ADD 17, STORE 17, HALT
        add_prog();
        prog[3] = 16'h008F;
        prog[4] = 16'h0000;
        start(1'b1);
        run_to_halt(40);
        check("st_ram17",   ram[17], 16'd7);
        check("st_model17", m_mem[17], 16'd7);
        check("st_wrcnt",   wr_cnt, 1);
        check("st_wraddr",  wr_addr, 5'd17);
        check("st_wrdata",  wr_data, 16'd7);

        // JZ taken after 3-3
        clear_prog();
        prog[16] = 16'd3;
        prog[17] = 16'd3;
        prog[1]  = 16'h0086;   // LOAD 16
        prog[2]  = 16'h018C;   // SUB 17
        prog[3]  = 16'h00A1;   // JZ 20
        prog[4]  = 16'h0003;   // NOP (skipped)
        prog[20] = 16'h0000;   // HALT
        start(1'b1);
        run_to_halt(40);
        check("jz_acc",       bus.aluin1, 16'd0);
        check("jz_model_flg", m_flg, 4'b0001);
        check("jz_model_pc",  m_pc, 5'd21);
        check("jz_lastfetch", fl(3), 5'd20);
        check("jz_nfetch",    fetch_log.size(), 4);

        // Enable dropped while the first LOAD reads its operand
        add_prog();
        start(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("en_read",   bus.read, 1'b0);
        check("en_write",  bus.write, 1'b0);
        check("en_halted", halted, 1'b0);
        check("en_acc",    bus.aluin1, 16'd5);
        check("en_nfetch", fetch_log.size(), 1);
        @(negedge clk);
        #2;
        fetch_log.delete();
        enable = 1'b1;
        run_to_halt(40);
        check("en_resume_pc", fl(0), 5'd2);
        check("en_acc_final", bus.aluin1, 16'd7);

        // Asynchronous reset in the middle of the write pulse
        add_prog();
        prog[3] = 16'h008F;
        prog[4] = 16'h0000;
        start(1'b1);
        n = 0;
        while (!bus.write && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ar_saw_write", bus.write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_write", bus.write, 1'b0);
        check("ar_addr",  bus.addressbus, 5'd0);
        check("ar_acc",   bus.aluin1, 16'd0);
        start(1'b1);
        @(posedge clk);
        #1;
        check("ar_pc1_read", bus.read, 1'b1);
        check("ar_pc1_addr", bus.addressbus, 5'd1);
        run_to_halt(40);
        check("ar_ram17", ram[17], 16'd7);

        // PC wrap: JMP 31, NOP at 31, HALT at 0
        clear_prog();
        prog[1]  = 16'h00FA;   // JMP 31
        prog[31] = 16'h0003;   // NOP
        prog[0]  = 16'h0000;   // HALT
        start(1'b1);
        run_to_halt(40);
        check("wrap_nfetch", fetch_log.size(), 3);
        check("wrap_f1",     fl(1), 5'd31);
        check("wrap_f2",     fl(2), 5'd0);
        check("wrap_halted", halted, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu_module.md
Name: cu_module

Overview:
- Multi-cycle accumulator control unit for the 16-bit teaching processor.
- Fetches instructions from an external level-sensitive RAM (RAMblock) over a shared address bus.
- Drives an external combinational ALU (ALUmodule) and sequences load, store, ALU, jump and halt instructions.
- Sits at the top of the datapath between RAMblock and ALUmodule; all three are instantiated side by side at system level.

Parameters:
- opsize, 3, ALU opcode width
- aluwidth, 16, ALU operand/result width
- numflags, 4, ALU flag width {V,C,N,Z} (bit0 = Z)
- adlines, 5, RAM address width (32 words)
- datalines, 16, RAM data width (equals aluwidth)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run enable
- aluopcode  out  opsize  opcode to ALU
- aluin1  out  aluwidth  ALU operand 1, always equals ACC
- aluin2  out  aluwidth  ALU operand 2, always equals MDR
- aluout  in  aluwidth  ALU result
- flags  in  numflags  ALU flags for the current operands
- addressbus  out  adlines  RAM address
- fromram  in  datalines  RAM read data, valid while read=1
- toram  out  datalines  RAM write data
- read  out  1  RAM read strobe
- write  out  1  RAM write strobe; RAM writes level-sensitively while high
- halted  out  1  high in HALT state

Behaviour:
- Instruction word fields:
  - [8] M
  - [7:3] addr
  - [2:0] op
  - [15:9] ignored
- Instruction decode:
  - Low 9 bits all zero: HALT.
  - M=1: ACC <= ALU(op, ACC, mem[addr]); FLAGS <= flags.
  - M=0, op=110: LOAD, ACC <= mem[addr]; FLAGS unchanged.
  - M=0, op=111: STORE, mem[addr] <= ACC.
  - M=0, op=010: JMP, PC <= addr.
  - M=0, op=001: JZ, PC <= addr if FLAGS[0].
  - Any other M=0 word: NOP.
- Registered outputs: all outputs are registered or decoded from registered state only.
- Reset state (async, rst_n low):
  - State IDLE, PC=1, ACC=0, IR=0, MDR=0, FLAGS=0.
  - read=0, write=0, addressbus=0, toram=0, aluopcode=0, halted=0.
- States and transitions:
  - IDLE: read=write=0. Goes to FETCH when enable=1.
  - FETCH: addressbus=PC, read=1. At edge: IR<=fromram, PC<=PC+1 (wraps 31->0). Next state is DECODE.
  - DECODE: read=0.
    - HALT -> HALT.
    - JMP/JZ/NOP resolve here -> FETCH (or IDLE if enable=0).
    - LOAD/ALU -> OPREAD.
    - STORE -> ST_SETUP.
  - OPREAD: addressbus=addr, read=1. At edge MDR<=fromram. Next state is EXEC.
  - EXEC: read=0, aluopcode=op. At edge ACC<=aluout (ALU) or MDR (LOAD).
  - ST_SETUP: addressbus=addr, toram=ACC, write=0.
  - ST_WR: write=1, address and data held.
  - ST_HOLD: write=0, address and data held.
- Instruction boundary: EXEC and ST_HOLD go to FETCH if enable=1, else IDLE.
- Enable: sampled only at instruction boundaries. Deassertion mid-instruction completes that instruction.
- HALT: halted=1, no bus activity. Only reset leaves HALT.
- Strobes: read and write are never both 1. Address and data are stable one cycle before, during and after write=1.
- Latency in cycles:
  - LOAD/ALU: 4
  - STORE: 5
  - JMP/JZ/NOP/HALT-decode: 2
- ALU (external, combinational) opcode map:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOT in1
  - 100 in1-in2
  - 101 in1<<1
  - 110 in1+in2
  - 111 pass in2
- ALU flags:
  - Z: result==0.
  - N: result[15].
  - C: carry/borrow out.
  - V: signed overflow.
- Arithmetic wraps modulo 2^16.
- Reset mid-store: write drops immediately (async). RAM contents at that address are undefined.

Decomposition:
- Shared package with:
  - The five width parameters.
  - ALU opcode constants.
  - Flag bit indices.
  - FSM state encoding.
  - Instruction field positions.
  - PC reset value 1.
- One natural sub-module: cu_decode, combinational classification of IR into HALT/LOAD/STORE/ALU/JMP/JZ/NOP.

Test Plan:
- Add program: mem[16]=5, mem[17]=2, mem[1]=0x086, mem[2]=0x18E, mem[3]=0x000; enable=1 -> ACC=7, halted=1 after 10 cycles, PC=4.
- Store: continue with mem[3]=0x08F (STORE 17), mem[4]=0 -> mem[17]=7; write high exactly 1 cycle with addressbus=17 held across ST_SETUP..ST_HOLD.
- JZ: mem[16]=3, mem[17]=3, program SUB 17 (0x18C), JZ 20 (0x0A1); mem[20]=0 -> Z=1, ACC=0, PC=21, halted.
- Enable gating: drop enable during OPREAD -> instruction completes, FSM parks in IDLE with read=write=0; re-raise -> resumes at next PC.
- Async reset mid-ST_WR: assert rst_n=0 -> write=0 and PC=1 immediately, no clock edge needed.
- PC wrap: JMP 31 where mem[31] is a NOP -> next fetch address is 0.
